// File: rtl/display_mux_driver.sv
// Avalon-MM driver for a time-multiplexed common-anode LED display.
// Double-buffered digit store, PWM brightness and frame-done interrupt.
module display_mux_driver #(
    parameter int num_digits = 4,
    parameter int seg_width  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  avs_s0_write,
    input  logic                  avs_s0_read,
    input  logic [3:0]            avs_s0_address,
    input  logic [31:0]           avs_s0_writedata,
    output logic [31:0]           avs_s0_readdata,
    output logic                  avs_s0_interrupt,
    output logic [num_digits-1:0] digit_sel,
    output logic [seg_width-1:0]  seg
);

    localparam int PW = (num_digits > 1) ? $clog2(num_digits) : 1;

    logic                 en;
    logic                 irq_en;
    logic                 frame_done;
    logic [31:0]          period;
    logic [31:0]          duty;
    logic [31:0]          slot_cnt;
    logic [PW-1:0]        pos;
    logic [seg_width-1:0] shadow [num_digits];
    logic [seg_width-1:0] active [num_digits];

    logic [31:0]           p_last;
    logic                  slot_end;
    logic                  last_pos;
    logic                  boundary;
    logic                  lit;
    logic [num_digits-1:0] sel_oh;
    logic [31:0]           rd_mux;

    always_comb begin
        p_last   = (period == 32'd0) ? 32'd0 : period - 32'd1;
        slot_end = (slot_cnt >= p_last);
        last_pos = (pos == PW'(num_digits - 1));
        boundary = en & slot_end & last_pos;
        lit      = en & (slot_cnt < duty);
        sel_oh   = num_digits'(1) << pos;
    end

    always_comb begin
        rd_mux = 32'd0;
        case (avs_s0_address)
            4'd0:    rd_mux = {30'd0, irq_en, en};
            4'd1:    rd_mux = {31'd0, frame_done};
            4'd2:    rd_mux = period;
            4'd3:    rd_mux = duty;
            default: rd_mux = 32'd0;
        endcase
        for (int k = 0; k < num_digits; k++) begin
            if (avs_s0_address == 4'(8 + k)) begin
                rd_mux = 32'(shadow[k]);
            end
        end
    end

    // Register file and host-visible status
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en         <= 1'b0;
            irq_en     <= 1'b0;
            frame_done <= 1'b0;
            period     <= 32'd0;
            duty       <= 32'd0;
            for (int k = 0; k < num_digits; k++) begin
                shadow[k] <= '0;
            end
        end else begin
            if (avs_s0_write) begin
                case (avs_s0_address)
                    4'd0: begin
                        en     <= avs_s0_writedata[0];
                        irq_en <= avs_s0_writedata[1];
                    end
                    4'd2:    period <= avs_s0_writedata;
                    4'd3:    duty   <= avs_s0_writedata;
                    default: ;
                endcase
            end
            for (int k = 0; k < num_digits; k++) begin
                if (avs_s0_write && avs_s0_address == 4'(8 + k)) begin
                    shadow[k] <= avs_s0_writedata[seg_width-1:0];
                end
            end
            // A frame boundary outranks a simultaneous clear
            if (boundary) begin
                frame_done <= 1'b1;
            end else if (avs_s0_write && avs_s0_address == 4'd1
                         && avs_s0_writedata[0]) begin
                frame_done <= 1'b0;
            end
        end
    end

    // Scan counters and the displayed copy of the digit store
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_cnt <= 32'd0;
            pos      <= '0;
            for (int k = 0; k < num_digits; k++) begin
                active[k] <= '0;
            end
        end else begin
            if (!en || boundary) begin
                for (int k = 0; k < num_digits; k++) begin
                    active[k] <= shadow[k];
                end
            end
            if (!en) begin
                slot_cnt <= 32'd0;
                pos      <= '0;
            end else if (slot_end) begin
                slot_cnt <= 32'd0;
                pos      <= last_pos ? '0 : pos + PW'(1);
            end else begin
                slot_cnt <= slot_cnt + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            avs_s0_readdata  <= 32'd0;
            avs_s0_interrupt <= 1'b0;
            digit_sel        <= '1;
            seg              <= '1;
        end else begin
            if (avs_s0_read) begin
                avs_s0_readdata <= rd_mux;
            end
            avs_s0_interrupt <= irq_en & frame_done;
            digit_sel        <= lit ? ~sel_oh : '1;
            seg              <= lit ? ~active[pos] : '1;
        end
    end

endmodule
